// File: rtl/lcd_frame_capture.sv
// Packs the 2-bit LCD pixel stream into a 160x144 byte-addressed framebuffer via a 4-entry write FIFO.
// Optional frame counter enabled by defining LCD_CAPTURE_FRAME_CNT_EN.
module lcd_frame_capture (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pixel_data,
  input  logic        pixel_clock,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        clear_err,
  output logic        fb_wr,
  input  logic        fb_ready,
  output logic [12:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        frame_done,
  output logic        busy,
  output logic        line_err,
  output logic        overflow,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {
    WAIT_VSYNC = 2'd0,
    ACTIVE     = 2'd1,
    FRAME_END  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        pclk_q, hsync_q, vsync_q;
  logic [7:0]  x_q, x_d;
  logic [7:0]  line_q, line_d;
  logic [5:0]  pack_q, pack_d;
  logic [12:0] addr_q [4];
  logic [12:0] addr_d [4];
  logic [7:0]  data_q [4];
  logic [7:0]  data_d [4];
  logic [2:0]  count_q, count_d;
  logic        fb_wr_q, fb_wr_d;
  logic        frame_done_q, frame_done_d;
  logic        busy_q, busy_d;
  logic        line_err_q, line_err_d;
  logic        overflow_q, overflow_d;

  logic        pclk_rise_s, hsync_rise_s, vsync_rise_s;
  logic        push_s, pop_s, line_err_set_s, overflow_set_s;
  logic [12:0] push_addr_s, line_base_s;
  logic [7:0]  push_data_s;
  logic [7:0]  x_tmp_s;
  logic [5:0]  pack_tmp_s;
  logic [2:0]  count_mid_s;

  assign pclk_rise_s  = pixel_clock & ~pclk_q;
  assign hsync_rise_s = hsync & ~hsync_q;
  assign vsync_rise_s = vsync & ~vsync_q;
  assign line_base_s  = {line_q, 5'b0} + {2'b0, line_q, 3'b0};

  // Capture FSM: pixel packing, line/frame sequencing and error detection.
  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    line_d         = line_q;
    pack_d         = pack_q;
    push_s         = 1'b0;
    push_addr_s    = 13'd0;
    push_data_s    = 8'd0;
    frame_done_d   = 1'b0;
    line_err_set_s = 1'b0;
    x_tmp_s        = x_q;
    pack_tmp_s     = pack_q;
    case (state_q)
      WAIT_VSYNC: begin
        if (vsync_rise_s) begin
          state_d = ACTIVE;
          x_d     = 8'd0;
          line_d  = 8'd0;
          pack_d  = 6'd0;
        end else begin
          state_d = WAIT_VSYNC;
        end
      end
      ACTIVE: begin
        if (vsync_rise_s) begin
          x_d            = 8'd0;
          line_d         = 8'd0;
          pack_d         = 6'd0;
          line_err_set_s = 1'b1;
        end else begin
          // The pixel is consumed before any hsync on the same cycle closes the line.
          if (pclk_rise_s) begin
            if (x_q < 8'd160) begin
              pack_tmp_s = {pack_q[3:0], pixel_data};
              x_tmp_s    = x_q + 8'd1;
              if (x_tmp_s[1:0] == 2'd0) begin
                push_s      = 1'b1;
                push_addr_s = line_base_s + {7'd0, x_q[7:2]};
                push_data_s = {pack_q, pixel_data};
              end else begin
                push_s = 1'b0;
              end
            end else begin
              line_err_set_s = 1'b1;
            end
          end else begin
            x_tmp_s = x_q;
          end
          if (hsync_rise_s) begin
            if (x_tmp_s < 8'd160) begin
              line_err_set_s = 1'b1;
              if (x_tmp_s[1:0] != 2'd0) begin
                push_s      = 1'b1;
                push_addr_s = line_base_s + {7'd0, x_tmp_s[7:2]};
                case (x_tmp_s[1:0])
                  2'd1:    push_data_s = {pack_tmp_s[1:0], 6'd0};
                  2'd2:    push_data_s = {pack_tmp_s[3:0], 4'd0};
                  2'd3:    push_data_s = {pack_tmp_s, 2'd0};
                  default: push_data_s = 8'd0;
                endcase
              end else begin
                push_s = push_s;
              end
            end else begin
              line_err_set_s = line_err_set_s;
            end
            x_d    = 8'd0;
            pack_d = 6'd0;
            if (line_q == 8'd143) begin
              state_d      = FRAME_END;
              frame_done_d = 1'b1;
              line_d       = 8'd0;
            end else begin
              line_d = line_q + 8'd1;
            end
          end else begin
            x_d    = x_tmp_s;
            pack_d = pack_tmp_s;
          end
        end
      end
      FRAME_END: state_d = WAIT_VSYNC;
      default:   state_d = WAIT_VSYNC;
    endcase
  end

  // Shift-register FIFO: entry 0 is the head, so the write port comes straight from flops.
  always_comb begin
    pop_s          = fb_wr_q & fb_ready;
    count_mid_s    = count_q - {2'd0, pop_s};
    overflow_set_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
    end
    if (pop_s) begin
      for (int i = 0; i < 3; i++) begin
        addr_d[i] = addr_q[i+1];
        data_d[i] = data_q[i+1];
      end
    end else begin
      addr_d[0] = addr_q[0];
    end
    if (push_s) begin
      if (count_mid_s < 3'd4) begin
        addr_d[count_mid_s[1:0]] = push_addr_s;
        data_d[count_mid_s[1:0]] = push_data_s;
        count_d                  = count_mid_s + 3'd1;
      end else begin
        overflow_set_s = 1'b1;
        count_d        = count_mid_s;
      end
    end else begin
      count_d = count_mid_s;
    end
    fb_wr_d    = (count_d != 3'd0);
    busy_d     = (state_d != WAIT_VSYNC) || (count_d != 3'd0);
    line_err_d = line_err_set_s | (line_err_q & ~clear_err);
    overflow_d = overflow_set_s | (overflow_q & ~clear_err);
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= WAIT_VSYNC;
      pclk_q       <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      x_q          <= 8'd0;
      line_q       <= 8'd0;
      pack_q       <= 6'd0;
      count_q      <= 3'd0;
      fb_wr_q      <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      line_err_q   <= 1'b0;
      overflow_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        addr_q[i] <= 13'd0;
        data_q[i] <= 8'd0;
      end
    end else begin
      state_q      <= state_d;
      pclk_q       <= pixel_clock;
      hsync_q      <= hsync;
      vsync_q      <= vsync;
      x_q          <= x_d;
      line_q       <= line_d;
      pack_q       <= pack_d;
      count_q      <= count_d;
      fb_wr_q      <= fb_wr_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      line_err_q   <= line_err_d;
      overflow_q   <= overflow_d;
      for (int i = 0; i < 4; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

`ifdef LCD_CAPTURE_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Counts in the same cycle frame_done is raised.
  always_comb begin
    if (frame_done_d) begin
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count_q <= 16'd0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = 16'd0;
`endif

  assign fb_wr      = fb_wr_q;
  assign fb_addr    = addr_q[0];
  assign fb_data    = data_q[0];
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign line_err   = line_err_q;
  assign overflow   = overflow_q;

endmodule
